mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Initiator side of the single-port, 1-cycle-read-latency 256x32 data RAM port (clk/we/addr/din/dout).
//   Accepts word load/store requests from the core over a valid/ready handshake.
//   Sequences RAM cycles and returns read data or a write acknowledge on a held response channel.
//   Sits between core LSU and RAM; the RAM instance is wired directly to the ram_* ports.
// PARAMETERS
//   ADDR_W  8   word address width; matches RAM depth 2**ADDR_W
//   DATA_W  32  data width; byte-lane logic requires DATA_W == 32
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   rstn       in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept; high only in IDLE
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   req_be     in   4       byte enables, be[0] = bits 7:0; used only with MEM_BYTE_STORE_EN
//   rsp_valid  out  1       response held until accepted
//   rsp_ready  in   1       core accepts response
//   rsp_rdata  out  DATA_W  load data; 0 for store acks
//   ram_we     out  1       RAM write enable, registered
//   ram_addr   out  ADDR_W  RAM address, registered
//   ram_din    out  DATA_W  RAM write data, registered
//   ram_dout   in   DATA_W  RAM read data, valid the cycle after the address edge
// BEHAVIOUR
//   - Reset (async, rstn=0): state=IDLE, ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_rdata=0.
//     Reset mid-operation aborts immediately: no response; a write with ram_we already high may or may not land.
//   - States: IDLE, ISSUE, CAPT, RSP (+ MRG, WR with macro). Accept = req_valid & req_ready (IDLE only).
//   - Load (edge E0 accept): ram_addr<=req_addr, ram_we<=0, ->ISSUE; E1: RAM samples, ->CAPT;
//     E2: rsp_rdata<=ram_dout, rsp_valid<=1, ->RSP. rsp_valid first visible 3 cycles after accept cycle.
//   - Store (full word): E0: ram_addr, ram_din<=req_wdata, ram_we<=1, ->ISSUE-as-write;
//     E1: RAM writes, ram_we<=0, rsp_rdata<=0, rsp_valid<=1, ->RSP. ram_we high exactly one cycle per write.
//   - RSP: rsp_valid/rsp_rdata stable until edge with rsp_ready=1; then rsp_valid<=0, ->IDLE.
//     rsp_ready sampled only in RSP. Next request accepted earliest the cycle after the response handshake.
//   - req_* are sampled only at the accept edge; later changes are ignored.
//   - Address is word-granular, ADDR_W bits, no arithmetic; 0x00 and 0xFF are ordinary addresses.
// CONFIGURATION
//   MEM_BYTE_STORE_EN defined:
//     - store with req_be==4'hF: full-word path as above.
//     - store with req_be==4'h0: no RAM access; rsp_valid<=1 at E0, ->RSP.
//     - other req_be: read-modify-write. E0 read issue ->ISSUE; E1 ->MRG;
//       E2 ram_din <= (ram_dout & ~M) | (wdata & M), M = byte-expanded be, ram_we<=1, ->WR;
//       E3 ram_we<=0, rsp_valid<=1, rsp_rdata<=0, ->RSP.
//   MEM_BYTE_STORE_EN undefined: req_be ignored, every store is full word; MRG/WR states absent.
//   req_be port present in both builds.
// TESTING
//   1. RAM[0x05]=0xDEADBEEF, load 0x05, rsp_ready=1 -> rsp_valid 3 cycles after accept, rdata=0xDEADBEEF, req_ready=0 meanwhile.
//   2. Store 0x10<-0x12345678 then load 0x10 -> ram_we high exactly 1 cycle, store ack rdata=0, load returns 0x12345678.
//   3. rsp_ready=0 for 5 cycles with req_valid held -> rsp_valid/rdata stable, req_ready=0; new req accepted cycle after handshake.
//   4. Back-to-back loads 0xFF then 0x00 (distinct preloads) -> each returns its own word, ram_addr correct each time.
//   5. RAM[0x20]=0xAABBCCDD, store be=4'b0101 wdata=0x11223344 -> RAM[0x20]=0xAA22CC44 with macro; 0x11223344 without.
//   6. rstn low during CAPT -> rsp_valid=0, ram_we=0 immediately; after release req_ready=1, no stale response.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a 1-cycle-latency single-port 256x32 RAM.
// Define MEM_BYTE_STORE_EN for byte-enable stores via read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    RSP
`ifdef MEM_BYTE_STORE_EN
    ,
    MRG,
    WR
`endif
  } state_t;

  state_t state, state_d;
  logic   wr_q;
  logic   accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

`ifdef MEM_BYTE_STORE_EN
  logic              rmw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] mask;
  logic              full_st;
  logic              nop_st;
  logic              rmw_st;

  assign full_st = req_we & (req_be == 4'hF);
  assign nop_st  = req_we & (req_be == 4'h0);
  assign rmw_st  = req_we & ~full_st & ~nop_st;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++)
      mask[8*i +: 8] = {8{be_q[i]}};
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MEM_BYTE_STORE_EN
          if (nop_st) state_d = RSP;
          else        state_d = ISSUE;
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
`ifdef MEM_BYTE_STORE_EN
        if (rmw_q)     state_d = MRG;
        else if (wr_q) state_d = RSP;
        else           state_d = CAPT;
`else
        if (wr_q) state_d = RSP;
        else      state_d = CAPT;
`endif
      end
      CAPT: state_d = RSP;
`ifdef MEM_BYTE_STORE_EN
      MRG: state_d = WR;
      WR:  state_d = RSP;
`endif
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_q      <= 1'b0;
`ifdef MEM_BYTE_STORE_EN
      rmw_q     <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef MEM_BYTE_STORE_EN
            wr_q    <= full_st;
            rmw_q   <= rmw_st;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            ram_we  <= full_st;
            if (!nop_st) ram_addr <= req_addr;
            if (full_st) ram_din <= req_wdata;
            // all-zero enables: nothing to write, ack at once
            if (nop_st) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end
`else
            wr_q     <= req_we;
            ram_we   <= req_we;
            ram_addr <= req_addr;
            if (req_we) ram_din <= req_wdata;
`endif
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          if (wr_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        CAPT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= ram_dout;
        end
`ifdef MEM_BYTE_STORE_EN
        MRG: begin
          ram_din <= (ram_dout & ~mask) | (wdata_q & mask);
          ram_we  <= 1'b1;
        end
        WR: begin
          ram_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
`endif
        RSP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 1-cycle RAM.
// Byte-store expectations follow MEM_BYTE_STORE_EN.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic [31:0] mem [256];
  logic [31:0] model [256];
  logic [31:0] sb [$];

  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          we_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we)       mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
    model[a] = d;
  endtask

  task automatic txn(input logic we, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int stall, input bit hold_req);
    int lat, exp_lat, wc0;
    logic [31:0] held, nw;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a;
    req_wdata = wd; req_be = be;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    if (we) begin
      nw = wd;
      exp_lat = 2;
`ifdef MEM_BYTE_STORE_EN
      if (be != 4'hF) exp_lat = 4;
      for (int b = 0; b < 4; b++)
        if (!be[b]) nw[8*b +: 8] = model[a][8*b +: 8];
`endif
      model[a] = nw;
      sb.push_back(32'd0);
    end else begin
      exp_lat = 3;
      sb.push_back(model[a]);
    end
    wc0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = 8'($urandom);
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("ram_addr", {24'd0, ram_addr}, {24'd0, a});
        check("busy_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    check("rsp_latency", lat, exp_lat);
    held = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      if (hold_req) req_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check("rdata", rsp_rdata, sb.pop_front());
    check("we_pulses", we_cnt - wc0, we ? 32'd1 : 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp20;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = 4'hF; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 'x;
    #3;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    preload(8'h05, 32'hDEADBEEF);
    preload(8'hFF, 32'hCAFEF00D);
    preload(8'h00, 32'h01234567);
    preload(8'h20, 32'hAABBCCDD);
    preload(8'h10, 32'h0BADF00D);

    txn(1'b0, 8'h05, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b1, 8'h10, 32'h12345678, 4'hF, 0, 1'b0);
    txn(1'b0, 8'h10, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b0, 8'h05, 32'h0, 4'hF, 5, 1'b1);
    txn(1'b0, 8'hFF, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b0, 8'h00, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b1, 8'h20, 32'h11223344, 4'b0101, 0, 1'b0);
    txn(1'b0, 8'h20, 32'h0, 4'hF, 2, 1'b0);
`ifdef MEM_BYTE_STORE_EN
    exp20 = 32'hAA22CC44;
`else
    exp20 = 32'h11223344;
`endif
    check("byte_store_word", model[8'h20], exp20);

    for (int i = 0; i < 4; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      a = 8'($urandom_range(32, 200));
      d = $urandom;
      txn(1'b1, a, d, 4'hF, i, 1'b0);
      txn(1'b0, a, 32'h0, 4'hF, 0, 1'b0);
    end

    // abort a load in CAPT with reset
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("ready_post_rst", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 8'hFF, 32'h0, 4'hF, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
